axis_frame_pad: RTL

AXIS_FRAME_PAD -- requirements
Module: axis_frame_pad

---
 rtl/axis_frame_pad.sv | 116 +++++++++++
 1 files changed

// File: rtl/axis_frame_pad.sv
// axis_frame_pad: pads short AXI-Stream frames with zero beats up to MIN_LEN beats.
// Optional build macro AXIS_FRAME_PAD_TRUNC_EN: truncates frames at MAX_LEN beats
// (last kept beat flagged with tuser) and drops the remainder of the frame.
module axis_frame_pad #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 1522
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser
);

    if (MIN_LEN < 1 || MAX_LEN < MIN_LEN || MAX_LEN >= 2 ** LEN_WIDTH) begin : g_param_check
        $error("axis_frame_pad: need 1 <= MIN_LEN <= MAX_LEN < 2**LEN_WIDTH");
    end

`ifdef AXIS_FRAME_PAD_TRUNC_EN
    typedef enum logic [1:0] {XFER, PAD, DROP} state_t;
    localparam logic [LEN_WIDTH:0] MAX_W = (LEN_WIDTH + 1)'(MAX_LEN);
`else
    typedef enum logic [1:0] {XFER, PAD} state_t;
`endif

    localparam logic [LEN_WIDTH:0] MIN_W = (LEN_WIDTH + 1)'(MIN_LEN);

    state_t               state;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic                 lat_user;
    logic                 out_en;
    logic                 accept;
    logic                 in_drop;
    logic                 reach_min;
    logic [LEN_WIDTH:0]   cnt_inc;
    logic [LEN_WIDTH-1:0] cnt_sat;

    assign out_en    = output_axis_tready || !output_axis_tvalid;
    assign cnt_inc   = {1'b0, beat_cnt} + (LEN_WIDTH + 1)'(1);
    assign cnt_sat   = &beat_cnt ? beat_cnt : cnt_inc[LEN_WIDTH-1:0];
    assign reach_min = cnt_inc >= MIN_W;
`ifdef AXIS_FRAME_PAD_TRUNC_EN
    assign in_drop   = state == DROP;
`else
    assign in_drop   = 1'b0;
`endif
    assign input_axis_tready = rst_n && (state == XFER ? out_en : in_drop);
    assign accept            = input_axis_tvalid && input_axis_tready;

    // Frame FSM and output register: pass beats, append zero pad beats, optionally truncate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= XFER;
            beat_cnt           <= '0;
            lat_user           <= 1'b0;
            output_axis_tvalid <= 1'b0;
            output_axis_tdata  <= '0;
            output_axis_tlast  <= 1'b0;
            output_axis_tuser  <= 1'b0;
        end else begin
            case (state)
                XFER: if (out_en) begin
                    output_axis_tvalid <= accept;
                    if (accept) begin
                        output_axis_tdata <= input_axis_tdata;
                        if (input_axis_tlast && !reach_min) begin
                            output_axis_tlast <= 1'b0;
                            output_axis_tuser <= 1'b0;
                            lat_user          <= input_axis_tuser;
                            beat_cnt          <= cnt_sat;
                            state             <= PAD;
                        end
`ifdef AXIS_FRAME_PAD_TRUNC_EN
                        else if (!input_axis_tlast && cnt_inc == MAX_W) begin
                            output_axis_tlast <= 1'b1;
                            output_axis_tuser <= 1'b1;
                            beat_cnt          <= '0;
                            state             <= DROP;
                        end
`endif
                        else begin
                            output_axis_tlast <= input_axis_tlast;
                            output_axis_tuser <= input_axis_tuser;
                            beat_cnt          <= input_axis_tlast ? '0 : cnt_sat;
                        end
                    end
                end
                PAD: if (out_en) begin
                    output_axis_tvalid <= 1'b1;
                    output_axis_tdata  <= '0;
                    output_axis_tlast  <= reach_min;
                    output_axis_tuser  <= reach_min && lat_user;
                    beat_cnt           <= reach_min ? '0 : cnt_sat;
                    if (reach_min) state <= XFER;
                end
`ifdef AXIS_FRAME_PAD_TRUNC_EN
                DROP: begin
                    if (out_en) output_axis_tvalid <= 1'b0;
                    if (accept && input_axis_tlast) state <= XFER;
                end
`endif
                default: state <= XFER;
            endcase
        end
    end

endmodule
